// File: rtl/npu_pkg.sv
// Shared NPU types and dimensions for the conv2 output / pooling stage.
package npu_pkg;

  localparam int CONV2_OUT_H = 12;
  localparam int CONV2_OUT_W = 11;
  localparam int CONV2_CHAN  = 10;
  localparam int POOL_OUT_H  = 6;
  localparam int POOL_OUT_W  = 5;
  localparam int POOL_SHIFT  = 8;

  typedef logic signed [23:0] acc24_t;
  typedef logic [7:0]         pix8_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } rd_state_t;

endpackage

// File: rtl/pool_requant.sv
// 2x2 signed max, ReLU, right-shift requant and saturation to unsigned 8-bit.
// CONV2_RD_ROUND_EN adds round-half-up before the shift.
module pool_requant
  import npu_pkg::*;
#(
  parameter int SHIFT = POOL_SHIFT
) (
  input  acc24_t a_i,
  input  acc24_t b_i,
  input  acc24_t c_i,
  input  acc24_t d_i,
  output pix8_t  pix_o
);

`ifdef CONV2_RD_ROUND_EN
  localparam logic signed [24:0] RND = 25'sd1 <<< (SHIFT - 1);
`endif

  acc24_t            m_ab;
  acc24_t            m_cd;
  acc24_t            mx;
  logic signed [24:0] ext;
  logic signed [24:0] q;

  always_comb begin
    m_ab = (a_i > b_i) ? a_i : b_i;
    m_cd = (c_i > d_i) ? c_i : d_i;
    mx   = (m_ab > m_cd) ? m_ab : m_cd;
    // ReLU first; 25 bits leaves headroom for the rounding add
    ext  = mx[23] ? 25'sd0 : {1'b0, mx};
`ifdef CONV2_RD_ROUND_EN
    ext  = ext + RND;
`endif
    q     = ext >>> SHIFT;
    pix_o = (q > 25'sd255) ? 8'hFF : q[7:0];
  end

endmodule

// File: rtl/conv2_pool_reader.sv
// Snapshots a conv2 channel map, max-pools/requantises it and streams 6x5 pixels.
// Optional round-half-up requant via CONV2_RD_ROUND_EN (see pool_requant).
module conv2_pool_reader
  import npu_pkg::*;
#(
  parameter int IN_H  = CONV2_OUT_H,
  parameter int IN_W  = CONV2_OUT_W,
  parameter int OUT_H = POOL_OUT_H,
  parameter int OUT_W = POOL_OUT_W,
  parameter int SHIFT = POOL_SHIFT,
  parameter int CHAN  = CONV2_CHAN
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [IN_H-1:0][IN_W-1:0][23:0] in_buff,
  input  logic                            frame_valid,
  input  logic [3:0]                      frame_chan,
  output logic                            busy,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [7:0]                      m_data,
  output logic [3:0]                      m_chan,
  output logic [2:0]                      m_row,
  output logic [2:0]                      m_col,
  output logic                            m_last,
  output logic                            m_last_chan,
  output logic                            overrun_err,
  output logic [1:0]                      dbg_state
);

  rd_state_t state_q, state_d;

  logic [IN_H-1:0][IN_W-1:0][23:0] snap_q;
  logic       snap_en;
  logic       load_px;
  logic       final_hs;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [3:0] chan_q, chan_d;
  logic       vld_q, vld_d;
  logic       last_q, last_d;
  logic       ovr_q, ovr_d;
  logic [2:0] orow_q, orow_d, ocol_q, ocol_d;
  pix8_t      data_q, data_d;
  pix8_t      pix;
  logic [3:0] r0, r1, c0, c1;

  assign r0 = {row_q, 1'b0};
  assign r1 = {row_q, 1'b1};
  assign c0 = {col_q, 1'b0};
  assign c1 = {col_q, 1'b1};

  pool_requant #(.SHIFT(SHIFT)) u_pool (
    .a_i   (snap_q[r0][c0]),
    .b_i   (snap_q[r0][c1]),
    .c_i   (snap_q[r1][c0]),
    .d_i   (snap_q[r1][c1]),
    .pix_o (pix)
  );

  // Handshake: a beat transfers on a rising edge where m_valid && m_ready.
  // While m_valid && !m_ready every m_* payload is frozen and m_valid stays
  // high; the output register only reloads when it is empty or transferring.
  assign final_hs = vld_q && m_ready && last_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    chan_d  = chan_q;
    vld_d   = vld_q;
    last_d  = last_q;
    data_d  = data_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    ovr_d   = ovr_q;
    snap_en = 1'b0;
    load_px = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          snap_en = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_px = 1'b1;
        state_d = STREAM;
        if (frame_valid) ovr_d = 1'b1;
      end
      STREAM: begin
        if (final_hs) begin
          vld_d  = 1'b0;
          last_d = 1'b0;
          // A frame arriving with the final handshake chains straight on
          if (frame_valid) begin
            snap_en = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (!vld_q || m_ready) load_px = 1'b1;
          if (frame_valid) ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (snap_en) begin
      chan_d = frame_chan;
      row_d  = '0;
      col_d  = '0;
    end

    if (load_px) begin
      vld_d  = 1'b1;
      data_d = pix;
      orow_d = row_q;
      ocol_d = col_q;
      last_d = (row_q == 3'(OUT_H - 1)) && (col_q == 3'(OUT_W - 1));
      if (col_q == 3'(OUT_W - 1)) begin
        col_d = '0;
        row_d = row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      chan_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      chan_q <= chan_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      data_q <= data_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      ovr_q  <= ovr_d;
    end
  end

  // Snapshot contents are don't-care after reset, so no reset on this bank
  always_ff @(posedge clk) begin
    if (snap_en) snap_q <= in_buff;
  end

  assign busy        = (state_q != IDLE);
  assign m_valid     = vld_q;
  assign m_data      = data_q;
  assign m_chan      = chan_q;
  assign m_row       = orow_q;
  assign m_col       = ocol_q;
  assign m_last      = last_q;
  assign m_last_chan = last_q && (chan_q == 4'(CHAN - 1));
  assign overrun_err = ovr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_conv2_pool_reader.sv
// Scoreboard bench for conv2_pool_reader; honours CONV2_RD_ROUND_EN in its model.
module tb_conv2_pool_reader;

  localparam int W = 20;

  logic                     clk;
  logic                     rst_n;
  logic [11:0][10:0][23:0]  in_buff;
  logic                     frame_valid;
  logic [3:0]               frame_chan;
  logic                     busy;
  logic                     m_valid;
  logic                     m_ready;
  logic [7:0]               m_data;
  logic [3:0]               m_chan;
  logic [2:0]               m_row;
  logic [2:0]               m_col;
  logic                     m_last;
  logic                     m_last_chan;
  logic                     overrun_err;
  logic [1:0]               dbg_state;

  conv2_pool_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_buff     (in_buff),
    .frame_valid (frame_valid),
    .frame_chan  (frame_chan),
    .busy        (busy),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_chan      (m_chan),
    .m_row       (m_row),
    .m_col       (m_col),
    .m_last      (m_last),
    .m_last_chan (m_last_chan),
    .overrun_err (overrun_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int img [12][11];
  int cap [6][5];
  int hs_cnt   = 0;
  int last_cnt = 0;
  int lc_cnt   = 0;
  int lat_req  = 0;
  int lat_done = 0;
  int lat_start = 0;
  int rdy_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_px(input int r, input int c);
    int mx;
    int q;
    mx = img[2*r][2*c];
    if (img[2*r][2*c+1]   > mx) mx = img[2*r][2*c+1];
    if (img[2*r+1][2*c]   > mx) mx = img[2*r+1][2*c];
    if (img[2*r+1][2*c+1] > mx) mx = img[2*r+1][2*c+1];
    if (mx < 0) mx = 0;
`ifdef CONV2_RD_ROUND_EN
    mx = mx + 128;
`endif
    q = mx / 256;
    if (q > 255) q = 255;
    return 8'(q);
  endfunction

  function automatic logic [W-1:0] mk_word(input logic [3:0] ch, input int r, input int c,
                                           input logic [7:0] d);
    logic last;
    logic lc;
    last = (r == 5) && (c == 4);
    lc   = last && (ch == 4'd9);
    return {ch, 3'(r), 3'(c), last, lc, d};
  endfunction

  function automatic int cap_sum();
    int s = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 5; c++) s += cap[r][c];
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_const(input int v);
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 11; j++) img[i][j] = v;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 11; j++) img[i][j] = (i * 11 + j) << 8;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 11; j++) img[i][j] = int'($urandom_range(0, 120000)) - 30000;
  endtask

  // Called just after a rising edge; frame_valid is sampled on the next one.
  task automatic pulse_fv(input logic [3:0] ch, input bit accept);
    int v;
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 11; j++) begin
        v = img[i][j];
        in_buff[i][j] = v[23:0];
      end
    if (accept) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 5; c++) exp_q.push_back(mk_word(ch, r, c, model_px(r, c)));
      lat_start = cyc;
      lat_req++;
    end
    frame_valid = 1'b1;
    frame_chan  = ch;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    frame_chan  = 4'($urandom_range(0, 15));
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 11; j++) in_buff[i][j] = 24'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_in_time", (exp_q.size() == 0) && !busy, 1);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (hs_cnt < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("beat_wait", hs_cnt >= target, 1);
  endtask

  // ---------------- ready driver ----------------
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph  = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: begin
          m_ready = pat[ph];
          ph = (ph + 1) % 4;
        end
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic         stall_q = 1'b0;
  logic [W-1:0] stall_word;
  always @(negedge clk) begin
    logic [W-1:0] word;
    logic [W-1:0] e;
    if (rst_n) begin
      word = {m_chan, m_row, m_col, m_last, m_last_chan, m_data};
      if (stall_q) begin
        check("valid_held", m_valid, 1);
        check("stall_stable", word, stall_word);
      end
      if (lat_done < lat_req && m_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        if (e[15:10] == 6'd0) begin
          check("first_beat_latency", cyc - lat_start, 2);
          lat_done++;
        end
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (m_last) last_cnt++;
        if (m_last_chan) lc_cnt++;
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat", word, e);
          cap[int'(e[15:13])][int'(e[12:10])] = int'(m_data);
        end
      end
      stall_q    = m_valid && !m_ready;
      stall_word = word;
    end else begin
      stall_q = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int b0;
    int l0;
    int c0;
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    frame_chan  = '0;
    in_buff     = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    check("rst_overrun", overrun_err, 0);
    check("rst_m_last", m_last, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Ramp, full throughput: beats on edges T+2..T+31
    fill_ramp();
    l0 = last_cnt; c0 = lc_cnt;
    pulse_fv(4'd3, 1'b1);
    repeat (30) @(posedge clk); #1;
    check("ramp_busy_t30", busy, 1);
    check("ramp_pending_t30", exp_q.size(), 1);
    @(posedge clk); #1;
    check("ramp_busy_t31", busy, 0);
    check("ramp_pending_t31", exp_q.size(), 0);
    check("ramp_p00", cap[0][0], 12);
    check("ramp_p54", cap[5][4], 130);
    check("ramp_last_cnt", last_cnt - l0, 1);
    check("ramp_lastchan_cnt", lc_cnt - c0, 0);

    // All negative -> ReLU to zero
    fill_const(-5000);
    pulse_fv(4'd0, 1'b1);
    wait_done();
    check("neg_sum", cap_sum(), 0);

    // Single max-positive word saturates its pooled pixel
    fill_const(0);
    img[4][6] = 32'h007F_FFFF;
    pulse_fv(4'd1, 1'b1);
    wait_done();
    check("sat_p23", cap[2][3], 255);
    check("sat_sum", cap_sum(), 255);

    // Column 10 is never read
    fill_const(0);
    img[0][10] = 32'h007F_FFFF;
    pulse_fv(4'd2, 1'b1);
    wait_done();
    check("dropcol_sum", cap_sum(), 0);

    // Requant rounding
    fill_const(384);
    pulse_fv(4'd4, 1'b1);
    wait_done();
`ifdef CONV2_RD_ROUND_EN
    check("round_p00", cap[0][0], 2);
`else
    check("trunc_p00", cap[0][0], 1);
`endif

    // Stall pattern 1,0,0,1 on the last channel
    rdy_mode = 1;
    fill_rand();
    c0 = lc_cnt;
    pulse_fv(4'd9, 1'b1);
    wait_done();
    check("stall_lastchan_cnt", lc_cnt - c0, 1);

    // Random backpressure, random channels
    rdy_mode = 2;
    for (int k = 0; k < 2; k++) begin
      fill_rand();
      pulse_fv(4'($urandom_range(0, 9)), 1'b1);
      wait_done();
    end

    // Back-to-back: new frame coincident with the final handshake
    rdy_mode = 0;
    fill_ramp();
    pulse_fv(4'd6, 1'b1);
    repeat (30) @(posedge clk); #1;
    fill_rand();
    pulse_fv(4'd7, 1'b1);
    check("b2b_busy", busy, 1);
    wait_done();
    check("b2b_no_overrun", overrun_err, 0);

    // Overrun mid-stream under random backpressure
    rdy_mode = 2;
    fill_rand();
    b0 = hs_cnt;
    pulse_fv(4'd8, 1'b1);
    wait_beats(b0 + 10);
    check("pre_overrun", overrun_err, 0);
    fill_rand();
    pulse_fv(4'd5, 1'b0);
    check("overrun_set", overrun_err, 1);
    wait_done();
    check("overrun_sticky", overrun_err, 1);

    // Asynchronous reset at beat 15
    rdy_mode = 0;
    fill_ramp();
    b0 = hs_cnt;
    pulse_fv(4'd3, 1'b1);
    wait_beats(b0 + 15);
    #2;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_m_data", m_data, 0);
    check("arst_m_row", m_row, 0);
    check("arst_m_col", m_col, 0);
    check("arst_m_chan", m_chan, 0);
    check("arst_m_last", m_last, 0);
    check("arst_lastchan", m_last_chan, 0);
    check("arst_overrun", overrun_err, 0);
    repeat (2) @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("post_rst_valid", m_valid, 0);
    check("post_rst_busy", busy, 0);
    fill_rand();
    pulse_fv(4'd2, 1'b1);
    wait_done();

    // Frame during LOAD is dropped and flags overrun
    fill_rand();
    pulse_fv(4'd1, 1'b1);
    pulse_fv(4'd2, 1'b0);
    wait_done();
    check("load_overrun", overrun_err, 1);

    repeat (3) @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
